// File: rtl/dmac_xfer_engine.sv
// Single-channel DMA sequencer: alternating read/write bus cycles from SAR to DAR,
// TCR times, with suspend/resume on GO and sticky TE/AE status.
module dmac_xfer_engine #(
  parameter int unsigned TCR_W = 24
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             GO,
  input  logic [31:0]      SAR_IN,
  input  logic [31:0]      DAR_IN,
  input  logic [TCR_W-1:0] TCR_IN,
  input  logic [1:0]       SM,
  input  logic [1:0]       DM,
  input  logic [1:0]       TS,
  input  logic             IE,
  input  logic             TE_CLR,
  output logic [31:0]      BUS_A,
  output logic [31:0]      BUS_DO,
  input  logic [31:0]      BUS_DI,
  output logic [3:0]       BUS_BA,
  output logic             BUS_WE,
  output logic             BUS_REQ,
  input  logic             BUS_BUSY,
  output logic [31:0]      SAR_CUR,
  output logic [31:0]      DAR_CUR,
  output logic [TCR_W-1:0] TCR_CUR,
  output logic             TE,
  output logic             AE,
  output logic             IRQ
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e           state_q, state_d;
  logic             act_q, act_d;
  logic [31:0]      sar_q, sar_d, dar_q, dar_d, hold_q, hold_d;
  logic [TCR_W-1:0] tcr_q, tcr_d, tcr_dec;
  logic             te_q, te_d, ae_q, ae_d, ld_q, ld_d;
  logic             te_set, ae_set, misalign;
  logic [2:0]       size;
  logic [3:0]       rd_ba, wr_ba;
  logic [31:0]      rd_shift, rd_data, wr_data;

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] ts);
    case (ts)
      2'b00:   lanes = 4'b1000 >> a[1:0];
      2'b01:   lanes = a[1] ? 4'b0011 : 4'b1100;
      default: lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] mode,
                                       input logic [2:0] sz);
    case (mode)
      2'b01:   step = a + {29'd0, sz};
      2'b10:   step = a - {29'd0, sz};
      default: step = a;
    endcase
  endfunction

  always_comb begin
    case (TS)
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
  end

  assign misalign = ((TS == 2'b01) & (SAR_IN[0] | DAR_IN[0])) |
                    (TS[1] & ((|SAR_IN[1:0]) | (|DAR_IN[1:0])));

  assign rd_ba    = lanes(sar_q, TS);
  assign wr_ba    = lanes(dar_q, TS);
  assign tcr_dec  = tcr_q - TCR_W'(1);
  // Offset 0 sits in bits 31:24, so a byte at offset n is shifted down by 8*(3-n).
  assign rd_shift = BUS_DI >> {~sar_q[1:0], 3'b000};

  always_comb begin
    case (TS)
      2'b00:   rd_data = {24'h0, rd_shift[7:0]};
      2'b01:   rd_data = sar_q[1] ? {16'h0, BUS_DI[15:0]} : {16'h0, BUS_DI[31:16]};
      default: rd_data = BUS_DI;
    endcase
    case (TS)
      2'b00:   wr_data = {4{hold_q[7:0]}};
      2'b01:   wr_data = {2{hold_q[15:0]}};
      default: wr_data = hold_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    sar_d   = sar_q;
    dar_d   = dar_q;
    tcr_d   = tcr_q;
    hold_d  = hold_q;
    ld_d    = ld_q;
    te_set  = 1'b0;
    ae_set  = 1'b0;
    if (CE) begin
      unique case (state_q)
        StIdle: begin
          if (GO && !te_q && !ae_q) begin
            if (ld_q && (tcr_q != '0)) begin
              state_d = StRd;
              act_d   = 1'b0;
            end else begin
              sar_d = SAR_IN;
              dar_d = DAR_IN;
              tcr_d = TCR_IN;
              if (misalign) begin
                ae_set = 1'b1;
              end else begin
                ld_d    = 1'b1;
                state_d = StRd;
                act_d   = 1'b0;
              end
            end
          end
        end
        StRd: begin
          // First cycle of each phase is the mandatory REQ-low gap.
          if (!act_q) begin
            act_d = 1'b1;
          end else if (!BUS_BUSY) begin
            hold_d  = rd_data;
            act_d   = 1'b0;
            state_d = StWr;
          end
        end
        StWr: begin
          if (!act_q) begin
            act_d = 1'b1;
          end else if (!BUS_BUSY) begin
            sar_d = step(sar_q, SM, size);
            dar_d = step(dar_q, DM, size);
            tcr_d = tcr_dec;
            act_d = 1'b0;
            if (tcr_dec == '0) begin
              state_d = StDone;
            end else if (GO) begin
              state_d = StRd;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDone: begin
          te_set  = 1'b1;
          ld_d    = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    te_d = te_q;
    if (CE && TE_CLR) te_d = 1'b0;
    if (te_set) te_d = 1'b1;
    ae_d = ae_q;
    if (CE && TE_CLR && !GO) ae_d = 1'b0;
    if (ae_set) ae_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      act_q   <= 1'b0;
      sar_q   <= '0;
      dar_q   <= '0;
      tcr_q   <= '0;
      hold_q  <= '0;
      te_q    <= 1'b0;
      ae_q    <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      sar_q   <= sar_d;
      dar_q   <= dar_d;
      tcr_q   <= tcr_d;
      hold_q  <= hold_d;
      te_q    <= te_d;
      ae_q    <= ae_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    BUS_A   = '0;
    BUS_DO  = '0;
    BUS_BA  = '0;
    BUS_WE  = 1'b0;
    BUS_REQ = 1'b0;
    if (state_q == StRd) begin
      BUS_A   = sar_q;
      BUS_BA  = rd_ba;
      BUS_REQ = act_q;
    end else if (state_q == StWr) begin
      BUS_A   = dar_q;
      BUS_BA  = wr_ba;
      BUS_DO  = wr_data;
      BUS_WE  = 1'b1;
      BUS_REQ = act_q;
    end
  end

  assign SAR_CUR = sar_q;
  assign DAR_CUR = dar_q;
  assign TCR_CUR = tcr_q;
  assign TE      = te_q;
  assign AE      = ae_q;
  assign IRQ     = te_q & IE;

endmodule

// File: tb/tb_dmac_xfer_engine.sv
// Bench for dmac_xfer_engine: directed scenarios plus randomized transfers checked
// against a byte-lane reference model of the expected bus transactions.
module tb_dmac_xfer_engine;
  localparam int unsigned TCR_W = 24;

  logic             CLK = 1'b0, RST_N = 1'b0, CE = 1'b0, GO = 1'b0, IE = 1'b0;
  logic             TE_CLR = 1'b0, BUS_BUSY = 1'b0;
  logic [31:0]      SAR_IN = '0, DAR_IN = '0, BUS_DI = '0;
  logic [TCR_W-1:0] TCR_IN = '0;
  logic [1:0]       SM = '0, DM = '0, TS = '0;
  logic [31:0]      BUS_A, BUS_DO, SAR_CUR, DAR_CUR;
  logic [3:0]       BUS_BA;
  logic             BUS_WE, BUS_REQ, TE, AE, IRQ;
  logic [TCR_W-1:0] TCR_CUR;

  dmac_xfer_engine #(.TCR_W(TCR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .GO(GO), .SAR_IN(SAR_IN), .DAR_IN(DAR_IN),
    .TCR_IN(TCR_IN), .SM(SM), .DM(DM), .TS(TS), .IE(IE), .TE_CLR(TE_CLR),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .BUS_BA(BUS_BA), .BUS_WE(BUS_WE),
    .BUS_REQ(BUS_REQ), .BUS_BUSY(BUS_BUSY), .SAR_CUR(SAR_CUR), .DAR_CUR(DAR_CUR),
    .TCR_CUR(TCR_CUR), .TE(TE), .AE(AE), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [3:0]  ba;
    logic [31:0] dout;
    logic [31:0] din;
    logic [31:0] cyc;
  } xact_t;

  xact_t       xq[$];
  logic [31:0] cyc_cnt = '0;
  int          errors = 0, checks = 0;
  logic        rnd = 1'b0;

  // Completed bus cycles as seen by the responder.
  always @(posedge CLK) begin
    cyc_cnt <= cyc_cnt + 32'd1;
    if (RST_N && CE && BUS_REQ && !BUS_BUSY)
      xq.push_back('{a: BUS_A, we: BUS_WE, ba: BUS_BA, dout: BUS_DO, din: BUS_DI, cyc: cyc_cnt});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd) begin
      CE       = ($urandom_range(0, 3) != 0);
      BUS_BUSY = ($urandom_range(0, 2) == 0);
      BUS_DI   = $urandom;
    end
  endtask

  // Lane k (0 = lowest address) maps to BA[3-k]; an access covers the size-aligned group.
  function automatic logic [3:0] exp_ba(input logic [31:0] a, input int s);
    int off;
    logic [3:0] r;
    r = '0;
    off = (s == 1) ? int'(a[1:0]) : (s == 2) ? (a[1] ? 2 : 0) : 0;
    for (int k = 0; k < 4; k++) if (k >= off && k < off + s) r[3-k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] ba);
    return {{8{ba[3]}}, {8{ba[2]}}, {8{ba[1]}}, {8{ba[0]}}};
  endfunction

  // Bytes read from the source lanes land, in address order, on the destination lanes.
  function automatic logic [31:0] move_bytes(input logic [31:0] di, input logic [3:0] rba,
                                             input logic [3:0] wba);
    logic [7:0]  b[4];
    logic [31:0] r;
    int          nb, j;
    nb = 0; j = 0; r = '0;
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'h00;
      if (rba[3-k]) begin b[nb] = di[31-8*k -: 8]; nb++; end
    end
    for (int k = 0; k < 4; k++) if (wba[3-k] && j < nb) begin r[31-8*k -: 8] = b[j]; j++; end
    return r;
  endfunction

  function automatic logic [31:0] adj(input logic [1:0] mode, input int s);
    if (mode == 2'b01) return 32'(s);
    if (mode == 2'b10) return 32'(-s);
    return 32'd0;
  endfunction

  task automatic check_xfers(input string tag, input int n, input logic [31:0] sar,
                             input logic [31:0] dar, input logic [TCR_W-1:0] tcr_in,
                             input logic [1:0] sm, input logic [1:0] dm, input logic [1:0] ts);
    int               s;
    logic [31:0]      sa, da, m;
    logic [3:0]       rb, wb;
    logic [TCR_W-1:0] et;
    s  = (ts == 2'b00) ? 1 : (ts == 2'b01) ? 2 : 4;
    sa = sar;
    da = dar;
    chk({tag, " count"}, 32'(xq.size()), 32'(2 * n));
    for (int i = 0; i < n && 2 * i + 1 < xq.size(); i++) begin
      rb = exp_ba(sa, s);
      wb = exp_ba(da, s);
      m  = lane_mask(wb);
      chk({tag, " rd addr"}, xq[2*i].a, sa);
      chk({tag, " rd we"}, 32'(xq[2*i].we), 32'd0);
      chk({tag, " rd ba"}, 32'(xq[2*i].ba), 32'(rb));
      chk({tag, " wr addr"}, xq[2*i+1].a, da);
      chk({tag, " wr we"}, 32'(xq[2*i+1].we), 32'd1);
      chk({tag, " wr ba"}, 32'(xq[2*i+1].ba), 32'(wb));
      chk({tag, " wr data"}, xq[2*i+1].dout & m, move_bytes(xq[2*i].din, rb, wb) & m);
      sa = sa + adj(sm, s);
      da = da + adj(dm, s);
    end
    et = tcr_in - TCR_W'(n);
    chk({tag, " sar_cur"}, SAR_CUR, sa);
    chk({tag, " dar_cur"}, DAR_CUR, da);
    chk({tag, " tcr_cur"}, 32'(TCR_CUR), 32'(et));
  endtask

  task automatic start(input logic [31:0] sar, input logic [31:0] dar,
                       input logic [TCR_W-1:0] tcr, input logic [1:0] sm, input logic [1:0] dm,
                       input logic [1:0] ts);
    SAR_IN = sar; DAR_IN = dar; TCR_IN = tcr; SM = sm; DM = dm; TS = ts;
    xq.delete();
    GO = 1'b1;
  endtask

  task automatic wait_te(input string tag, input int budget);
    for (int k = 0; k < budget && TE !== 1'b1; k++) tick();
    chk({tag, " te set"}, 32'(TE), 32'd1);
  endtask

  task automatic clear_te();
    GO = 1'b0; CE = 1'b1; BUS_BUSY = 1'b0;
    TE_CLR = 1'b1;
    tick();
    TE_CLR = 1'b0;
  endtask

  initial begin
    logic [31:0] a0, d0, sar, dar;
    logic [3:0]  b0;
    logic        seen;
    logic [1:0]  ts, sm, dm;
    int          s;
    logic [TCR_W-1:0] tcr;

    // Reset state
    CE = 1'b1;
    tick(); tick();
    chk("rst req", 32'(BUS_REQ), 32'd0);
    chk("rst a", BUS_A, 32'd0);
    chk("rst ba", 32'(BUS_BA), 32'd0);
    chk("rst we", 32'(BUS_WE), 32'd0);
    chk("rst do", BUS_DO, 32'd0);
    chk("rst sar", SAR_CUR, 32'd0);
    chk("rst dar", DAR_CUR, 32'd0);
    chk("rst tcr", 32'(TCR_CUR), 32'd0);
    chk("rst te", 32'(TE), 32'd0);
    chk("rst ae", 32'(AE), 32'd0);
    chk("rst irq", 32'(IRQ), 32'd0);
    RST_N = 1'b1;
    tick();

    // Long, incrementing, zero-wait
    IE = 1'b1; BUS_DI = 32'hCAFE_F00D;
    start(32'h1000, 32'h2000, 24'd3, 2'b01, 2'b01, 2'b10);
    wait_te("long", 100);
    check_xfers("long", 3, 32'h1000, 32'h2000, 24'd3, 2'b01, 2'b01, 2'b10);
    chk("long spacing", (xq.size() == 6) ? xq[5].cyc - xq[0].cyc : 32'hFFFF_FFFF, 32'd10);
    chk("long irq", 32'(IRQ), 32'd1);
    clear_te();
    chk("te_clr te", 32'(TE), 32'd0);
    chk("te_clr irq", 32'(IRQ), 32'd0);

    // Byte, fixed source, decrementing destination
    IE = 1'b0; BUS_DI = 32'h1122_3344;
    start(32'h1001, 32'h2003, 24'd2, 2'b00, 2'b10, 2'b00);
    wait_te("byte", 100);
    check_xfers("byte", 2, 32'h1001, 32'h2003, 24'd2, 2'b00, 2'b10, 2'b00);
    chk("byte rd ba", (xq.size() > 0) ? 32'(xq[0].ba) : 32'hFFFF_FFFF, 32'h4);
    chk("byte wr0", (xq.size() > 1) ? {24'h0, xq[1].dout[7:0]} : 32'hFFFF_FFFF, 32'h22);
    chk("byte wr1", (xq.size() > 3) ? {24'h0, xq[3].dout[15:8]} : 32'hFFFF_FFFF, 32'h22);
    clear_te();

    // BUSY stall on the first write
    BUS_DI = 32'hDEAD_BEEF;
    start(32'h3000, 32'h4000, 24'd1, 2'b01, 2'b01, 2'b10);
    for (int k = 0; k < 50 && !(BUS_REQ && BUS_WE); k++) tick();
    chk("busy wr seen", 32'(BUS_REQ & BUS_WE), 32'd1);
    BUS_BUSY = 1'b1;
    a0 = BUS_A; d0 = BUS_DO; b0 = BUS_BA;
    repeat (3) begin
      tick();
      chk("busy a", BUS_A, a0);
      chk("busy do", BUS_DO, d0);
      chk("busy ba", 32'(BUS_BA), 32'(b0));
      chk("busy we/req", 32'({BUS_WE, BUS_REQ}), 32'd3);
      chk("busy tcr", 32'(TCR_CUR), 32'd1);
    end
    BUS_BUSY = 1'b0;
    tick();
    chk("busy tcr after", 32'(TCR_CUR), 32'd0);
    wait_te("busy", 20);
    check_xfers("busy", 1, 32'h3000, 32'h4000, 24'd1, 2'b01, 2'b01, 2'b10);
    clear_te();

    // Misaligned word destination
    start(32'h5000, 32'h2001, 24'd1, 2'b01, 2'b01, 2'b01);
    seen = 1'b0;
    repeat (6) begin tick(); seen |= BUS_REQ; end
    chk("ae no req", 32'(seen), 32'd0);
    chk("ae set", 32'(AE), 32'd1);
    chk("ae te", 32'(TE), 32'd0);
    TE_CLR = 1'b1; tick(); TE_CLR = 1'b0;
    chk("ae kept while go", 32'(AE), 32'd1);
    GO = 1'b0; TE_CLR = 1'b1; tick(); TE_CLR = 1'b0;
    chk("ae cleared", 32'(AE), 32'd0);

    // GO dropped during the second read, then resumed
    BUS_DI = 32'h0123_4567;
    start(32'h6000, 32'h7000, 24'd4, 2'b01, 2'b01, 2'b10);
    for (int k = 0; k < 100 && xq.size() < 2; k++) tick();
    GO = 1'b0;
    repeat (12) tick();
    chk("godrop count", 32'(xq.size()), 32'd4);
    chk("godrop tcr", 32'(TCR_CUR), 32'd2);
    chk("godrop sar", SAR_CUR, 32'h6008);
    chk("godrop te", 32'(TE), 32'd0);
    chk("godrop req", 32'(BUS_REQ), 32'd0);
    GO = 1'b1;
    wait_te("resume", 100);
    check_xfers("resume", 4, 32'h6000, 32'h7000, 24'd4, 2'b01, 2'b01, 2'b10);
    clear_te();

    // TCR_IN = 0 means 2^TCR_W transfers
    start(32'h8000, 32'h9000, 24'd0, 2'b01, 2'b01, 2'b10);
    for (int k = 0; k < 100 && xq.size() < 1; k++) tick();
    GO = 1'b0;
    repeat (10) tick();
    chk("tcr0 count", 32'(xq.size()), 32'd2);
    chk("tcr0 tcr", 32'(TCR_CUR), 32'h00FF_FFFF);
    chk("tcr0 te", 32'(TE), 32'd0);

    // Asynchronous reset while a write is pending
    GO = 1'b1;
    for (int k = 0; k < 50 && !(BUS_REQ && BUS_WE); k++) tick();
    chk("rstwr seen", 32'(BUS_REQ & BUS_WE), 32'd1);
    BUS_BUSY = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("rstwr req", 32'(BUS_REQ), 32'd0);
    chk("rstwr a", BUS_A, 32'd0);
    chk("rstwr we/ba", 32'({BUS_WE, BUS_BA}), 32'd0);
    chk("rstwr do", BUS_DO, 32'd0);
    chk("rstwr sar", SAR_CUR, 32'd0);
    chk("rstwr dar", DAR_CUR, 32'd0);
    chk("rstwr tcr", 32'(TCR_CUR), 32'd0);
    GO = 1'b0; BUS_BUSY = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Randomized transfers with random CE, BUSY and read data
    for (int r = 0; r < 8; r++) begin
      ts = 2'($urandom_range(0, 3));
      sm = 2'($urandom_range(0, 3));
      dm = 2'($urandom_range(0, 3));
      s  = (ts == 2'b00) ? 1 : (ts == 2'b01) ? 2 : 4;
      sar = $urandom;
      dar = $urandom;
      if ($urandom_range(0, 3) == 0) sar = sar | 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) dar = dar & 32'h0000_000F;
      sar = sar & ~32'(s - 1);
      dar = dar & ~32'(s - 1);
      tcr = TCR_W'($urandom_range(1, 5));
      IE  = 1'($urandom_range(0, 1));
      start(sar, dar, tcr, sm, dm, ts);
      rnd = 1'b1;
      wait_te("rand", 600);
      rnd = 1'b0; CE = 1'b1; BUS_BUSY = 1'b0;
      check_xfers("rand", int'(tcr), sar, dar, tcr, sm, dm, ts);
      chk("rand irq", 32'(IRQ), 32'(IE));
      clear_te();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
